// File: rtl/mannix_arb_pkg.sv
// Shared definitions for the mannix read/write arbiters: client indices,
// arbiter state encoding and burst limits.
package mannix_arb_pkg;

    // Client slot assignments on the shared memory-farm read port
    localparam int FCC_PIC  = 0;
    localparam int FCC_WGT  = 1;
    localparam int FCC_BIAS = 2;
    localparam int CNN_PIC  = 3;
    localparam int CNN_WGT  = 4;
    localparam int CNN_BIAS = 5;
    localparam int POOL_MX  = 6;

    // Longest burst in words; a zero length field wraps to this value
    localparam int MAX_BURST = 16;

    // Width of the priority-client selector; values >= client count mean "none"
    localparam int PRIO_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage : mannix_arb_pkg

// File: rtl/mannix_rr_pick.sv
// Combinational winner selection: a requesting priority client wins outright,
// otherwise the first requester at or after rr_ptr in circular order wins.
// Kept free of state so the same picker can serve a write arbiter later.
module mannix_rr_pick
    import mannix_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 7,
    parameter int CL_W        = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic [CL_W-1:0]        i_rr_ptr,
    input  logic [PRIO_W-1:0]      i_prio,
    output logic [CL_W-1:0]        o_winner,
    output logic                   o_found,
    output logic                   o_prio_hit
);

    logic [CL_W-1:0] w_prio_idx;
    logic            w_prio_hit;
    logic [CL_W-1:0] w_rr_idx;
    logic            w_rr_found;

    // Priority client match; an out-of-range selector never matches any slot
    always_comb begin
        w_prio_hit = 1'b0;
        w_prio_idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (i_req[i] && (i_prio == PRIO_W'(i))) begin
                w_prio_hit = 1'b1;
                w_prio_idx = CL_W'(i);
            end else begin
                w_prio_hit = w_prio_hit;
            end
        end
    end

    // Circular scan starting at the round-robin pointer; first hit wins
    always_comb begin
        int idx;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        idx        = 0;
        for (int off = 0; off < NUM_CLIENTS; off++) begin
            idx = int'(i_rr_ptr) + off;
            if (idx >= NUM_CLIENTS) begin
                idx = idx - NUM_CLIENTS;
            end else begin
                idx = idx;
            end
            if (!w_rr_found && i_req[idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = CL_W'(idx);
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Merge the two policies: priority overrides round-robin
    always_comb begin
        o_prio_hit = w_prio_hit;
        o_found    = w_prio_hit | w_rr_found;
        if (w_prio_hit) begin
            o_winner = w_prio_idx;
        end else begin
            o_winner = w_rr_idx;
        end
    end

endmodule : mannix_rr_pick

// File: rtl/mannix_rd_arbiter.sv
// Read-port arbiter for the mannix memory farm. Grants one client a burst at
// a time, forwards the request to memory, and routes read-valid beats back to
// the granted client until the burst length is exhausted.
module mannix_rd_arbiter
    import mannix_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 7,
    parameter int ADDR_WIDTH  = 19,
    parameter int LEN_WIDTH   = 5,
    parameter int CL_W        = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PRIO_W-1:0]                 client_priority,
    input  logic [NUM_CLIENTS-1:0]            cl_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  cl_len,
    output logic [NUM_CLIENTS-1:0]            cl_gnt,
    output logic [NUM_CLIENTS-1:0]            cl_rd_valid,
    output logic                              cl_busy,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [LEN_WIDTH-1:0]              mem_len,
    input  logic                              mem_ack,
    input  logic                              mem_rd_valid
);

    // Zero in the length field means a full-size burst
    function automatic logic [LEN_WIDTH-1:0] burst_beats(input logic [LEN_WIDTH-1:0] len);
        if (len == '0) begin
            return LEN_WIDTH'(MAX_BURST);
        end else begin
            return len;
        end
    endfunction

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [CL_W-1:0]       r_winner;
    logic [CL_W-1:0]       r_rr_ptr;
    logic                  r_prio_win;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;

    logic [CL_W-1:0]       w_pick_winner;
    logic                  w_pick_found;
    logic                  w_pick_prio;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]  w_sel_len;
    logic [CL_W-1:0]       w_rr_next;
    logic                  w_last_beat;

    mannix_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .CL_W        (CL_W)
    ) u_pick (
        .i_req      (cl_req),
        .i_rr_ptr   (r_rr_ptr),
        .i_prio     (client_priority),
        .o_winner   (w_pick_winner),
        .o_found    (w_pick_found),
        .o_prio_hit (w_pick_prio)
    );

    // Mux the winning client's address and length out of the packed buses
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_sel_addr = w_sel_addr |
                (cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_pick_winner == CL_W'(i)}});
            w_sel_len  = w_sel_len |
                (cl_len[i*LEN_WIDTH +: LEN_WIDTH] & {LEN_WIDTH{w_pick_winner == CL_W'(i)}});
        end
    end

    // Burst-end detection and the round-robin successor of the current winner
    always_comb begin
        w_last_beat = (r_state == DATA) && mem_rd_valid && (r_cnt <= LEN_WIDTH'(1));
        if (r_winner >= CL_W'(NUM_CLIENTS - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = r_winner + CL_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_next_state = REQ;
                end else begin
                    w_next_state = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_next_state = DATA;
                end else begin
                    w_next_state = REQ;
                end
            end
            DATA: begin
                if (w_last_beat) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DATA;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Burst context: winner capture, beat counting and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner   <= '0;
            r_rr_ptr   <= '0;
            r_prio_win <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_winner   <= w_pick_winner;
                        r_prio_win <= w_pick_prio;
                        r_addr     <= w_sel_addr;
                        r_len      <= w_sel_len;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        r_cnt <= burst_beats(r_len);
                    end
                end
                DATA: begin
                    if (mem_rd_valid) begin
                        r_cnt <= r_cnt - LEN_WIDTH'(1);
                        if (w_last_beat && !r_prio_win) begin
                            r_rr_ptr <= w_rr_next;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; grant and read-valid are one-hot
    always_comb begin
        cl_gnt      = '0;
        cl_rd_valid = '0;
        mem_req     = (r_state == REQ);
        cl_busy     = (r_state != IDLE);
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cl_gnt[i]      = (r_state == REQ)  && mem_ack      && (r_winner == CL_W'(i));
            cl_rd_valid[i] = (r_state == DATA) && mem_rd_valid && (r_winner == CL_W'(i));
        end
    end

    assign mem_addr = r_addr;
    assign mem_len  = r_len;

endmodule : mannix_rd_arbiter

// File: tb/tb_mannix_rd_arbiter.sv
// Directed bench for mannix_rd_arbiter: a table of bursts with hand-computed
// winners, addresses and beat counts, plus reset-mid-burst and stray-valid
// sequences.
module tb_mannix_rd_arbiter;
    import mannix_arb_pkg::*;

    localparam int NC = 7;
    localparam int AW = 19;
    localparam int LW = 5;

    logic            clk;
    logic            rst_n;
    logic [4:0]      client_priority;
    logic [NC-1:0]   cl_req;
    logic [NC*AW-1:0] cl_addr;
    logic [NC*LW-1:0] cl_len;
    logic [NC-1:0]   cl_gnt;
    logic [NC-1:0]   cl_rd_valid;
    logic            cl_busy;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_len;
    logic            mem_ack;
    logic            mem_rd_valid;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [6:0]  req;
        logic [4:0]  prio;
        logic [4:0]  len;
        int          ack_dly;
        int          nbeats;
        int          exp_cl;
        logic [18:0] exp_addr;
    } vec_t;

    vec_t        vecs [12];
    logic [18:0] addr_tab [NC];

    mannix_rd_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .client_priority (client_priority),
        .cl_req          (cl_req),
        .cl_addr         (cl_addr),
        .cl_len          (cl_len),
        .cl_gnt          (cl_gnt),
        .cl_rd_valid     (cl_rd_valid),
        .cl_busy         (cl_busy),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_len         (mem_len),
        .mem_ack         (mem_ack),
        .mem_rd_valid    (mem_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        cl_req          = v.req;
        client_priority = v.prio;
        for (int i = 0; i < NC; i++) begin
            cl_addr[i*AW +: AW] = addr_tab[i];
            cl_len[i*LW +: LW]  = v.len;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         lat;
        logic [6:0] exp_oh;
        exp_oh = 7'b0000001 << v.exp_cl;
        set_inputs(v);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_req && lat < 8);
        chk($sformatf("v%0d req_latency", idx), 32'(lat), 32'd1);
        if (!mem_req) return;
        chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d mem_len", idx), 32'(mem_len), 32'(v.len));
        chk($sformatf("v%0d busy_req", idx), 32'(cl_busy), 32'd1);
        for (int i = 0; i < v.ack_dly; i++) begin
            mem_rd_valid = (v.ack_dly > 5);
            #1;
            chk($sformatf("v%0d stall_gnt", idx), 32'(cl_gnt), 32'd0);
            chk($sformatf("v%0d stall_rdv", idx), 32'(cl_rd_valid), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d stall_req", idx), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d stall_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
            chk($sformatf("v%0d stall_len", idx), 32'(mem_len), 32'(v.len));
        end
        mem_rd_valid = 1'b0;
        mem_ack      = 1'b1;
        #1;
        chk($sformatf("v%0d gnt", idx), 32'(cl_gnt), 32'(exp_oh));
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk($sformatf("v%0d req_drop", idx), 32'(mem_req), 32'd0);
        chk($sformatf("v%0d gnt_pulse", idx), 32'(cl_gnt), 32'd0);
        for (int b = 0; b < v.nbeats; b++) begin
            mem_rd_valid = 1'b1;
            #1;
            chk($sformatf("v%0d rdv_b%0d", idx, b), 32'(cl_rd_valid), 32'(exp_oh));
            @(posedge clk); #1;
            mem_rd_valid = 1'b0;
            if (b < v.nbeats - 1) begin
                chk($sformatf("v%0d busy_b%0d", idx, b), 32'(cl_busy), 32'd1);
            end else begin
                chk($sformatf("v%0d idle_end", idx), 32'(cl_busy), 32'd0);
            end
        end
    endtask

    initial begin
        vec_t r;
        int   lat;

        addr_tab[0] = 19'h01000;
        addr_tab[1] = 19'h02000;
        addr_tab[2] = 19'h03000;
        addr_tab[3] = 19'h00100;
        addr_tab[4] = 19'h05000;
        addr_tab[5] = 19'h06000;
        addr_tab[6] = 19'h07000;

        //            req          prio   len    dly beats winner    addr
        vecs[0]  = '{7'b0100101, 5'd31, 5'd1,  0, 1,  FCC_PIC,  19'h01000};
        vecs[1]  = '{7'b0100101, 5'd31, 5'd1,  0, 1,  FCC_BIAS, 19'h03000};
        vecs[2]  = '{7'b0100101, 5'd31, 5'd1,  0, 1,  CNN_BIAS, 19'h06000};
        vecs[3]  = '{7'b0100101, 5'd31, 5'd1,  0, 1,  FCC_PIC,  19'h01000};
        vecs[4]  = '{7'b1000001, 5'd6,  5'd2,  0, 2,  POOL_MX,  19'h07000};
        vecs[5]  = '{7'b0000101, 5'd31, 5'd1,  0, 1,  FCC_BIAS, 19'h03000};
        vecs[6]  = '{7'b0001000, 5'd31, 5'd4,  2, 4,  CNN_PIC,  19'h00100};
        vecs[7]  = '{7'b0010000, 5'd31, 5'd2, 10, 2,  CNN_WGT,  19'h05000};
        vecs[8]  = '{7'b0100000, 5'd31, 5'd0,  1, 16, CNN_BIAS, 19'h06000};
        vecs[9]  = '{7'b0000110, 5'd2,  5'd1,  0, 1,  FCC_BIAS, 19'h03000};
        vecs[10] = '{7'b1000010, 5'd7,  5'd3,  0, 3,  POOL_MX,  19'h07000};
        vecs[11] = '{7'b1000010, 5'd3,  5'd1,  0, 1,  FCC_WGT,  19'h02000};

        rst_n           = 1'b0;
        client_priority = 5'd31;
        cl_req          = '0;
        cl_addr         = '0;
        cl_len          = '0;
        mem_ack         = 1'b0;
        mem_rd_valid    = 1'b0;

        #3;
        chk("rst_gnt",  32'(cl_gnt),      32'd0);
        chk("rst_rdv",  32'(cl_rd_valid), 32'd0);
        chk("rst_busy", 32'(cl_busy),     32'd0);
        chk("rst_req",  32'(mem_req),     32'd0);
        chk("rst_addr", 32'(mem_addr),    32'd0);
        chk("rst_len",  32'(mem_len),     32'd0);

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of an 8-beat burst
        r = '{7'b0001000, 5'd31, 5'd8, 0, 8, CNN_PIC, 19'h00100};
        set_inputs(r);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_req && lat < 8);
        chk("mb req_latency", 32'(lat), 32'd1);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        cl_req  = '0;
        for (int b = 0; b < 2; b++) begin
            mem_rd_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("mb busy_before", 32'(cl_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mb rst_busy", 32'(cl_busy),     32'd0);
        chk("mb rst_rdv",  32'(cl_rd_valid), 32'd0);
        chk("mb rst_req",  32'(mem_req),     32'd0);
        chk("mb rst_gnt",  32'(cl_gnt),      32'd0);
        chk("mb rst_addr", 32'(mem_addr),    32'd0);
        chk("mb rst_len",  32'(mem_len),     32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mb leftover_rdv",  32'(cl_rd_valid), 32'd0);
            chk("mb leftover_busy", 32'(cl_busy),     32'd0);
        end
        mem_rd_valid = 1'b0;
        // rr_ptr back at 0 after reset, so client 0 beats client 3
        r = '{7'b0001001, 5'd31, 5'd1, 0, 1, FCC_PIC, 19'h01000};
        run_vec(r, 12);

        cl_req = '0;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_mannix_rd_arbiter
